bnn_window_xnor_mac: RTL and testbench



---
 rtl/bnn_mac_pkg.sv | 26 ++
 rtl/bnn_popcount.sv | 25 ++
 rtl/bnn_window_xnor_mac.sv | 163 ++++++++++++++++
 tb/tb_bnn_window_xnor_mac.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_mac_pkg.sv
// ============================================================================
//  Module : bnn_mac_pkg
//  Brief  : Shared constants and FSM encoding for the BNN window XNOR-MAC.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bnn_mac_pkg;

    localparam int KERNEL    = 5;
    localparam int KK        = KERNEL * KERNEL;
    localparam int SUM_WIDTH = 5;
    // Holds a column count up to the largest legal strip length (255).
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bnn_popcount.sv
// ============================================================================
//  Module : bnn_popcount
//  Brief  : Combinational population count of a WIDTH-bit vector.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bnn_popcount #(
    parameter int WIDTH = 25,
    parameter int OUT_W = 5
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [OUT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bnn_window_xnor_mac.sv
// ============================================================================
//  Module : bnn_window_xnor_mac
//  Brief  : Pops binary columns from the ifmaps FIFO into a KERNELxKERNEL
//           window and emits one XNOR-popcount partial sum per new column.
//           Optional macro BNN_MAC_THRESHOLD_EN adds threshold_in / act_out.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bnn_window_xnor_mac #(
    parameter int DATA_WIDTH = 1,
    parameter int KERNEL     = bnn_mac_pkg::KERNEL,
    parameter int ROW_LEN    = 32,
    parameter int SUM_WIDTH  = bnn_mac_pkg::SUM_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [KERNEL*DATA_WIDTH-1:0] fifo_col_in,
    input  logic                         fifo_empty,
    output logic                         fifo_read,
    input  logic [KERNEL*KERNEL-1:0]     weight_in,
    input  logic                         weight_load,
    input  logic                         start,
`ifdef BNN_MAC_THRESHOLD_EN
    input  logic [SUM_WIDTH-1:0]         threshold_in,
    output logic                         act_out,
`endif
    output logic [SUM_WIDTH-1:0]         psum_out,
    output logic                         psum_valid,
    output logic                         busy,
    output logic                         done
);

    import bnn_mac_pkg::*;

    localparam int WK = KERNEL * KERNEL;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]       col_cnt_q, col_cnt_d;
    logic                   col_vld_q;
    logic                   launch_q, launch_d;
    logic [WK-1:0]          window_q, window_d;
    logic [WK-1:0]          weight_q, weight_d;
    logic [SUM_WIDTH-1:0]   psum_q, psum_d;
    logic                   psum_valid_q, psum_valid_d;
    logic [SUM_WIDTH-1:0]   w_pop;
    logic [CNT_W-1:0]       w_col_next;
    logic                   w_accept;

    assign w_col_next = col_cnt_q + CNT_W'(1);
    assign w_accept   = (state_q == IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // col_vld_q marks the cycle the FIFO presents the column popped last cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = FILL;
            FILL: begin
                if (col_vld_q && w_col_next == CNT_W'(ROW_LEN))     state_d = DRAIN;
                else if (col_vld_q && w_col_next == CNT_W'(KERNEL)) state_d = RUN;
            end
            RUN:   if (col_vld_q && w_col_next == CNT_W'(ROW_LEN)) state_d = DRAIN;
            DRAIN: if (psum_valid_q && !launch_q) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        fifo_read = ((state_q == FILL) || (state_q == RUN)) && !fifo_empty
                    && (rd_cnt_q < CNT_W'(ROW_LEN));
        busy      = (state_q == FILL) || (state_q == RUN) || (state_q == DRAIN);
        done      = (state_q == DONE);
    end

    bnn_popcount #(
        .WIDTH (WK),
        .OUT_W (SUM_WIDTH)
    ) u_popcount (
        .bits_i  (~(window_q ^ weight_q)),
        .count_o (w_pop)
    );

    // ---------------- datapath next state ----------------
    always_comb begin
        rd_cnt_d     = rd_cnt_q;
        col_cnt_d    = col_cnt_q;
        window_d     = window_q;
        weight_d     = weight_q;
        launch_d     = 1'b0;
        psum_d       = psum_q;
        psum_valid_d = launch_q;

        if (w_accept && weight_load) weight_d = weight_in;
        if (w_accept && start) begin
            rd_cnt_d  = '0;
            col_cnt_d = '0;
            window_d  = '0;
        end
        if (fifo_read) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        // Newest column enters at the top; column 0 (oldest) falls off.
        if (col_vld_q) begin
            window_d  = {fifo_col_in, window_q[WK-1:KERNEL]};
            col_cnt_d = w_col_next;
            launch_d  = (w_col_next >= CNT_W'(KERNEL));
        end
        if (launch_q) psum_d = w_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q     <= '0;
            col_cnt_q    <= '0;
            col_vld_q    <= 1'b0;
            launch_q     <= 1'b0;
            window_q     <= '0;
            weight_q     <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
        end else begin
            rd_cnt_q     <= rd_cnt_d;
            col_cnt_q    <= col_cnt_d;
            col_vld_q    <= fifo_read;
            launch_q     <= launch_d;
            window_q     <= window_d;
            weight_q     <= weight_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
        end
    end

    assign psum_out   = psum_q;
    assign psum_valid = psum_valid_q;

`ifdef BNN_MAC_THRESHOLD_EN
    logic [SUM_WIDTH-1:0] thr_q;
    logic                 act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= '0;
            act_q <= 1'b0;
        end else begin
            if (w_accept && weight_load) thr_q <= threshold_in;
            if (launch_q)                act_q <= (w_pop >= thr_q);
        end
    end

    assign act_out = act_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bnn_window_xnor_mac.sv
// ============================================================================
//  Module : tb_bnn_window_xnor_mac
//  Brief  : Self-checking bench with a FIFO model and a window/popcount model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bnn_window_xnor_mac;

    localparam int K  = 5;
    localparam int KK = K * K;
    localparam int RL = 8;
    localparam int SW = 5;
    localparam int NP = RL - K + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [K-1:0]  fifo_col_in = '0;
    logic          fifo_empty;
    logic          fifo_read;
    logic [KK-1:0] weight_in = '0;
    logic          weight_load = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] psum_out;
    logic          psum_valid, busy, done;
`ifdef BNN_MAC_THRESHOLD_EN
    logic [SW-1:0] threshold_in = '0;
    logic          act_out;
`endif

    always #5 clk = ~clk;

    bnn_window_xnor_mac #(
        .DATA_WIDTH (1),
        .KERNEL     (K),
        .ROW_LEN    (RL),
        .SUM_WIDTH  (SW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_col_in  (fifo_col_in),
        .fifo_empty   (fifo_empty),
        .fifo_read    (fifo_read),
        .weight_in    (weight_in),
        .weight_load  (weight_load),
        .start        (start),
`ifdef BNN_MAC_THRESHOLD_EN
        .threshold_in (threshold_in),
        .act_out      (act_out),
`endif
        .psum_out     (psum_out),
        .psum_valid   (psum_valid),
        .busy         (busy),
        .done         (done)
    );

    // FIFO model: one-cycle read latency, head = rd_ptr + skip.
    logic [K-1:0] fifo_data [1024];
    int n_cols = 0;
    int rd_ptr = 0;
    int skip   = 0;

    always_comb fifo_empty = (rd_ptr + skip >= n_cols);

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_col_in <= fifo_data[rd_ptr + skip];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_p[$];
    bit exp_a[$];
    int tot_pulses = 0, tot_done = 0, run_len = 0, last_psum = -1;
    bit last_act = 1'b0, prev_v = 1'b0;
    int cp;
    bit ca;

    // Compare process: every cycle, sampled 1ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checks++;
            if (fifo_read && fifo_empty) begin
                errors++;
                $display("FAIL read_while_empty fifo_read=%0b fifo_empty=%0b", fifo_read, fifo_empty);
            end
            if (psum_valid) begin
                tot_pulses++;
                run_len = prev_v ? run_len + 1 : 1;
                checks++;
                if (exp_p.size() == 0) begin
                    errors++;
                    $display("FAIL psum_unexpected got=%0d expected none", psum_out);
                end else begin
                    cp = exp_p.pop_front();
                    ca = exp_a.pop_front();
                    if (psum_out !== SW'(cp)) begin
                        errors++;
                        $display("FAIL psum got=%0d exp=%0d", psum_out, cp);
                    end
`ifdef BNN_MAC_THRESHOLD_EN
                    checks++;
                    if (act_out !== ca) begin
                        errors++;
                        $display("FAIL act got=%0b exp=%0b (psum %0d)", act_out, ca, cp);
                    end
                    last_act = act_out;
`endif
                end
                last_psum = int'(psum_out);
            end
            if (done) begin
                tot_done++;
                checks++;
                if (!prev_v || exp_p.size() != 0 || busy) begin
                    errors++;
                    $display("FAIL done_timing prev_valid=%0b pending=%0d busy=%0b exp prev_valid=1 pending=0 busy=0",
                             prev_v, exp_p.size(), busy);
                end
            end
            prev_v = psum_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    logic [K-1:0] strip_cols [RL];

    // Reference: window j covers columns j..j+K-1; bit c*K+r = column c, row r.
    task automatic launch_strip(input logic [KK-1:0] w, input int thr);
        int p;
        for (int j = 0; j < NP; j++) begin
            p = 0;
            for (int c = 0; c < K; c++)
                for (int r = 0; r < K; r++)
                    if (strip_cols[j + c][r] == w[c * K + r]) p++;
            exp_p.push_back(p);
            exp_a.push_back(p >= thr);
        end
        @(negedge clk);
        skip        = n_cols - rd_ptr;
        weight_in   = w;
`ifdef BNN_MAC_THRESHOLD_EN
        threshold_in = SW'(thr);
`endif
        weight_load = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        weight_load = 1'b0;
        start       = 1'b0;
        weight_in   = KK'($urandom);
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic feed(input int gap_after, input bit rand_gaps);
        int budget;
        for (int i = 0; i < RL; i++) begin
            if (rand_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            fifo_data[n_cols] = strip_cols[i];
            n_cols++;
            if (i == gap_after) begin
                budget = 0;
                while (rd_ptr + skip < n_cols && budget < 50) begin
                    @(negedge clk);
                    budget++;
                end
                chk("gap_reached", rd_ptr + skip, n_cols);
                for (int g = 0; g < 3; g++) begin
                    chk("gap_fifo_read", int'(fifo_read), 0);
                    @(negedge clk);
                end
                chk("gap_no_psum", int'(psum_valid), 0);
            end
        end
    endtask

    task automatic finish_strip();
        int budget;
        budget = 0;
        while (!done && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        chk("done_seen", int'(done), 1);
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
    endtask

    task automatic run_strip(input logic [KK-1:0] w, input int thr, input int gap_after, input bit rand_gaps);
        launch_strip(w, thr);
        feed(gap_after, rand_gaps);
        finish_strip();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, budget;

        // 1: reset and idle
        repeat (2) @(negedge clk);
        chk("rst_psum_valid", int'(psum_valid), 0);
        chk("rst_psum_out", int'(psum_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;
        fifo_data[n_cols] = 5'b10101;
        n_cols++;
        repeat (4) begin
            @(negedge clk);
            chk("idle_fifo_read", int'(fifo_read), 0);
            chk("idle_psum_valid", int'(psum_valid), 0);
            chk("idle_busy", int'(busy), 0);
        end

        // 2: all ones against all-ones weight
        for (int i = 0; i < RL; i++) strip_cols[i] = 5'b11111;
        t0 = tot_pulses;
        run_strip(25'h1FFFFFF, 13, -1, 1'b0);
        chk("t2_pulses", tot_pulses - t0, NP);
        chk("t2_consecutive", run_len, NP);
        chk("t2_psum25", last_psum, 25);
`ifdef BNN_MAC_THRESHOLD_EN
        chk("t6_act_psum25", int'(last_act), 1);
`endif

        // 3: zero weight, 10101 columns, then 00000 columns
        for (int i = 0; i < RL; i++) strip_cols[i] = 5'b10101;
        run_strip('0, 13, -1, 1'b0);
        chk("t3_psum10", last_psum, 10);
`ifdef BNN_MAC_THRESHOLD_EN
        chk("t6_act_psum10", int'(last_act), 0);
`endif
        for (int i = 0; i < RL; i++) strip_cols[i] = 5'b00000;
        run_strip('0, 13, -1, 1'b0);
        chk("t3_psum25_cleared", last_psum, 25);

        // 4: FIFO empty for 3 cycles after the 6th column
        for (int i = 0; i < RL; i++) strip_cols[i] = K'($urandom);
        t0 = tot_pulses;
        run_strip(KK'($urandom), 12, 5, 1'b0);
        chk("t4_pulses", tot_pulses - t0, NP);

        // 5: reset during RUN
        for (int i = 0; i < RL; i++) strip_cols[i] = K'($urandom);
        t0 = tot_pulses;
        launch_strip(KK'($urandom), 7);
        feed(-1, 1'b0);
        budget = 0;
        while (tot_pulses == t0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("t5_reached_run", int'(tot_pulses > t0), 1);
        rst_n = 1'b0;
        exp_p.delete();
        exp_a.delete();
        #1;
        chk("t5_rst_psum_valid", int'(psum_valid), 0);
        chk("t5_rst_psum_out", int'(psum_out), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_fifo_read", int'(fifo_read), 0);
        chk("t5_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = tot_done;
        repeat (10) @(negedge clk);
        chk("t5_no_done", tot_done, d0);
        for (int i = 0; i < RL; i++) strip_cols[i] = K'($urandom);
        run_strip(KK'($urandom), 9, -1, 1'b0);

        // randomized strips with random empty gaps
        for (int s = 0; s < 12; s++) begin
            for (int i = 0; i < RL; i++) strip_cols[i] = K'($urandom);
            t0 = tot_pulses;
            run_strip(KK'($urandom), int'($urandom_range(0, 25)), -1, 1'b1);
            chk("rand_pulses", tot_pulses - t0, NP);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
